// File: rtl/swervolf_branch_stats_pkg.sv
// Shared constants and helpers for the branch statistics block.
// Covers register offsets, CTRL bit positions, counter width and the counter arithmetic.
package swervolf_branch_stats_pkg;

    localparam int CNT_W = 32;

    localparam logic [4:0] ADR_CTRL       = 5'h00;
    localparam logic [4:0] ADR_TOTAL      = 5'h04;
    localparam logic [4:0] ADR_TAKEN      = 5'h08;
    localparam logic [4:0] ADR_MISPRED    = 5'h0C;
    localparam logic [4:0] ADR_SNAP_TOTAL = 5'h10;
    localparam logic [4:0] ADR_SNAP_TAKEN = 5'h14;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_CLR     = 1;
    localparam int CTRL_SNAP    = 2;
    localparam int CTRL_OVF_LSB = 8;

    typedef enum logic [2:0] {
        REG_CTRL       = ADR_CTRL[4:2],
        REG_TOTAL      = ADR_TOTAL[4:2],
        REG_TAKEN      = ADR_TAKEN[4:2],
        REG_MISPRED    = ADR_MISPRED[4:2],
        REG_SNAP_TOTAL = ADR_SNAP_TOTAL[4:2],
        REG_SNAP_TAKEN = ADR_SNAP_TAKEN[4:2],
        REG_RSVD6      = 3'd6,
        REG_RSVD7      = 3'd7
    } reg_sel_e;

    // Increment with either saturation at all-ones or wrap to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic inc,
                                                 input logic saturate);
        logic [CNT_W-1:0] res;
        if (!inc) begin
            res = value;
        end else if (value == {CNT_W{1'b1}}) begin
            res = saturate ? value : {CNT_W{1'b0}};
        end else begin
            res = value + CNT_W'(1);
        end
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] byte_merge(input logic [CNT_W-1:0] old_value,
                                                    input logic [CNT_W-1:0] new_value,
                                                    input logic [CNT_W/8-1:0] be);
        logic [CNT_W-1:0] res;
        for (int b = 0; b < CNT_W/8; b++) begin
            res[8*b +: 8] = be[b] ? new_value[8*b +: 8] : old_value[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/swervolf_branch_stats_sat_counter.sv
// Event counter with clear, byte-wise load and saturating or wrapping increment.
// Priority is clear, then load, then increment; ovf_pulse flags an increment at all-ones.
module bs_sat_counter
    import swervolf_branch_stats_pkg::*;
#(
    parameter bit SATURATE = 1'b1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               inc,
    input  logic               clr,
    input  logic               load,
    input  logic [CNT_W-1:0]   load_data,
    input  logic [CNT_W/8-1:0] load_be,
    output logic [CNT_W-1:0]   count,
    output logic               ovf_pulse
);

    logic [CNT_W-1:0] count_r;

    // Counter register update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= byte_merge(count_r, load_data, load_be);
        end else begin
            count_r <= sat_inc(count_r, inc, SATURATE);
        end
    end

    assign ovf_pulse = inc & ~clr & ~load & (count_r == {CNT_W{1'b1}});
    assign count     = count_r;

endmodule

// File: rtl/swervolf_branch_stats.sv
// Retired-branch statistics counters with a Wishbone register interface.
// Counts total, taken and mispredicted branches; supports clear, snapshot and overflow flags.
module swervolf_branch_stats
    import swervolf_branch_stats_pkg::*;
#(
    parameter bit SATURATE = 1'b1,
    parameter bit EN_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_br_valid,
    input  logic             i_br_taken,
    input  logic             i_br_mispred,
    input  logic [4:0]       i_wb_adr,
    input  logic [31:0]      i_wb_dat,
    input  logic [3:0]       i_wb_sel,
    input  logic             i_wb_we,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    output logic [31:0]      o_wb_rdt,
    output logic             o_wb_ack,
    output logic [CNT_W-1:0] o_branches_counter,
    output logic [CNT_W-1:0] o_branches_taken_counter
);

    logic             ack_r;
    logic [31:0]      rdt_r;
    logic             enable_r;
    logic [2:0]       ovf_r;
    logic [CNT_W-1:0] snap_total_r;
    logic [CNT_W-1:0] snap_taken_r;

    logic             wb_go_s;
    logic             wr_s;
    logic             ctrl_wr_s;
    logic             clr_s;
    logic             snap_s;
    logic [2:0]       w1c_s;
    logic [2:0]       inc_s;
    logic [2:0]       load_s;
    logic [2:0]       ovf_pulse_s;
    logic [CNT_W-1:0] total_s;
    logic [CNT_W-1:0] taken_s;
    logic [CNT_W-1:0] mispred_s;
    logic [31:0]      rd_data_s;
    reg_sel_e         reg_sel_s;
    logic             unused_s;

    // An access is accepted (and all its side effects applied) on the edge that raises ack.
    assign wb_go_s   = i_wb_cyc & i_wb_stb & ~ack_r;
    assign wr_s      = wb_go_s & i_wb_we;
    assign reg_sel_s = reg_sel_e'(i_wb_adr[4:2]);
    assign ctrl_wr_s = wr_s & (reg_sel_s == REG_CTRL);
    assign clr_s     = ctrl_wr_s & i_wb_sel[0] & i_wb_dat[CTRL_CLR];
    assign snap_s    = ctrl_wr_s & i_wb_sel[0] & i_wb_dat[CTRL_SNAP];
    assign w1c_s     = (ctrl_wr_s & i_wb_sel[1]) ? i_wb_dat[CTRL_OVF_LSB +: 3] : 3'b000;

    assign inc_s[0]  = enable_r & i_br_valid;
    assign inc_s[1]  = enable_r & i_br_valid & i_br_taken;
    assign inc_s[2]  = enable_r & i_br_valid & i_br_mispred;

    assign load_s[0] = wr_s & (reg_sel_s == REG_TOTAL);
    assign load_s[1] = wr_s & (reg_sel_s == REG_TAKEN);
    assign load_s[2] = wr_s & (reg_sel_s == REG_MISPRED);

    assign unused_s  = ^i_wb_adr[1:0];

    bs_sat_counter #(.SATURATE(SATURATE)) u_total (
        .clk(clk), .rstn(rstn), .inc(inc_s[0]), .clr(clr_s), .load(load_s[0]),
        .load_data(i_wb_dat), .load_be(i_wb_sel), .count(total_s), .ovf_pulse(ovf_pulse_s[0])
    );

    bs_sat_counter #(.SATURATE(SATURATE)) u_taken (
        .clk(clk), .rstn(rstn), .inc(inc_s[1]), .clr(clr_s), .load(load_s[1]),
        .load_data(i_wb_dat), .load_be(i_wb_sel), .count(taken_s), .ovf_pulse(ovf_pulse_s[1])
    );

    bs_sat_counter #(.SATURATE(SATURATE)) u_mispred (
        .clk(clk), .rstn(rstn), .inc(inc_s[2]), .clr(clr_s), .load(load_s[2]),
        .load_data(i_wb_dat), .load_be(i_wb_sel), .count(mispred_s), .ovf_pulse(ovf_pulse_s[2])
    );

    // Enable bit and sticky overflow flags; a new overflow wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            enable_r <= EN_RESET;
            ovf_r    <= 3'b000;
        end else begin
            if (ctrl_wr_s && i_wb_sel[0]) begin
                enable_r <= i_wb_dat[CTRL_EN];
            end
            ovf_r <= (ovf_r & ~w1c_s) | ovf_pulse_s;
        end
    end

    // Snapshot takes the post-event values, ignoring a same-cycle clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snap_total_r <= {CNT_W{1'b0}};
            snap_taken_r <= {CNT_W{1'b0}};
        end else if (snap_s) begin
            snap_total_r <= sat_inc(total_s, inc_s[0], SATURATE);
            snap_taken_r <= sat_inc(taken_s, inc_s[1], SATURATE);
        end
    end

    // Register read multiplexer.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (reg_sel_s)
            REG_CTRL: begin
                rd_data_s[CTRL_EN]            = enable_r;
                rd_data_s[CTRL_OVF_LSB +: 3]  = ovf_r;
            end
            REG_TOTAL:      rd_data_s = total_s;
            REG_TAKEN:      rd_data_s = taken_s;
            REG_MISPRED:    rd_data_s = mispred_s;
            REG_SNAP_TOTAL: rd_data_s = snap_total_r;
            REG_SNAP_TAKEN: rd_data_s = snap_taken_r;
            default:        rd_data_s = 32'h0000_0000;
        endcase
    end

    // Single-cycle ack with read data held only while ack is high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack_r <= 1'b0;
            rdt_r <= 32'h0000_0000;
        end else begin
            ack_r <= wb_go_s;
            rdt_r <= wb_go_s ? rd_data_s : 32'h0000_0000;
        end
    end

    assign o_wb_ack                 = ack_r;
    assign o_wb_rdt                 = rdt_r;
    assign o_branches_counter       = total_s;
    assign o_branches_taken_counter = taken_s;

endmodule

// File: tb/tb_swervolf_branch_stats.sv
// Bench for swervolf_branch_stats: a saturating and a wrapping instance driven in lockstep
// and compared against a behavioural model of the counters and registers.
module tb_swervolf_branch_stats;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        br_valid = 1'b0, br_taken = 1'b0, br_mispred = 1'b0;
    logic [4:0]  wb_adr = 5'd0;
    logic [31:0] wb_dat = 32'd0;
    logic [3:0]  wb_sel = 4'd0;
    logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
    logic [31:0] rdt1, rdt0, tot1, tak1, tot0, tak0;
    logic        ack1, ack0;

    int checks = 0;
    int failures = 0;

    // model state: index 1 = saturating instance, 0 = wrapping instance
    logic [31:0] m_cnt [2][3];
    logic [31:0] m_snap [2][2];
    logic [2:0]  m_ovf [2];
    logic        m_en;

    swervolf_branch_stats #(.SATURATE(1'b1), .EN_RESET(1'b1)) dut_sat (
        .clk(clk), .rstn(rstn), .i_br_valid(br_valid), .i_br_taken(br_taken),
        .i_br_mispred(br_mispred), .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel),
        .i_wb_we(wb_we), .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .o_wb_rdt(rdt1), .o_wb_ack(ack1),
        .o_branches_counter(tot1), .o_branches_taken_counter(tak1)
    );

    swervolf_branch_stats #(.SATURATE(1'b0), .EN_RESET(1'b1)) dut_wrap (
        .clk(clk), .rstn(rstn), .i_br_valid(br_valid), .i_br_taken(br_taken),
        .i_br_mispred(br_mispred), .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel),
        .i_wb_we(wb_we), .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .o_wb_rdt(rdt0), .o_wb_ack(ack0),
        .o_branches_counter(tot0), .o_branches_taken_counter(tak0)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 3; k++) m_cnt[s][k] = 32'd0;
            m_snap[s][0] = 32'd0;
            m_snap[s][1] = 32'd0;
            m_ovf[s] = 3'b000;
        end
        m_en = 1'b1;
    endtask

    function automatic logic [31:0] m_read(input int s, input logic [4:0] adr);
        logic [31:0] r;
        r = 32'd0;
        case (adr[4:2])
            3'd0: begin r[0] = m_en; r[10:8] = m_ovf[s]; end
            3'd1: r = m_cnt[s][0];
            3'd2: r = m_cnt[s][1];
            3'd3: r = m_cnt[s][2];
            3'd4: r = m_snap[s][0];
            3'd5: r = m_snap[s][1];
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // One clock edge of the model: branch event plus an optional accepted bus write.
    task automatic m_cycle(input logic v, input logic t, input logic mp, input logic wr,
                           input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic clr, snap, inc, ld, pulse, ctrl;
        logic [2:0] w1c;
        logic [31:0] post;
        ctrl = wr && (adr[4:2] == 3'd0);
        clr  = ctrl && sel[0] && dat[1];
        snap = ctrl && sel[0] && dat[2];
        w1c  = (ctrl && sel[1]) ? dat[10:8] : 3'b000;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 3; k++) begin
                inc   = m_en && v && (k == 0 || (k == 1 && t) || (k == 2 && mp));
                ld    = wr && (adr[4:2] == 3'(k + 1));
                post  = m_cnt[s][k];
                pulse = 1'b0;
                if (inc) begin
                    if (post == 32'hFFFF_FFFF) begin
                        post  = (s == 1) ? post : 32'd0;
                        pulse = !clr && !ld;
                    end else begin
                        post = post + 32'd1;
                    end
                end
                if (snap && k < 2) m_snap[s][k] = post;
                if (clr) begin
                    m_cnt[s][k] = 32'd0;
                end else if (ld) begin
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) post[8*b +: 8] = dat[8*b +: 8];
                        else post[8*b +: 8] = m_cnt[s][k][8*b +: 8];
                    m_cnt[s][k] = post;
                end else begin
                    m_cnt[s][k] = post;
                end
                m_ovf[s][k] = (m_ovf[s][k] & ~w1c[k]) | pulse;
            end
        end
        if (ctrl && sel[0]) m_en = dat[0];
    endtask

    task automatic br_cycle(input logic v, input logic t, input logic mp);
        br_valid = v; br_taken = t; br_mispred = mp;
        @(posedge clk);
        m_cycle(v, t, mp, 1'b0, 5'd0, 32'd0, 4'd0);
        #1;
        br_valid = 1'b0; br_taken = 1'b0; br_mispred = 1'b0;
    endtask

    // Bus access; branch inputs already set by the caller land on the accepting edge.
    task automatic wb_xfer(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                           input logic we, output logic [31:0] r1, output logic [31:0] r0);
        logic bv, bt, bm, got;
        bv = br_valid; bt = br_taken; bm = br_mispred;
        wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = we; wb_cyc = 1'b1; wb_stb = 1'b1;
        got = 1'b0; r1 = 32'd0; r0 = 32'd0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ack1) begin
                got = 1'b1; r1 = rdt1; r0 = rdt0;
                m_cycle(bv, bt, bm, we, adr, dat, sel);
            end
            br_valid = 1'b0; br_taken = 1'b0; br_mispred = 1'b0;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL wb_ack_timeout adr=%h got no ack, required ack within 4 cycles", adr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] r1, r0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (tot1 !== 32'd0 || tak1 !== 32'd0 || ack1 !== 1'b0 || rdt1 !== 32'd0) begin
            failures++;
            $display("FAIL reset_state tot=%h tak=%h ack=%b rdt=%h, required all 0", tot1, tak1, ack1, rdt1);
        end
        rstn = 1'b1;
        m_reset();
        wb_xfer(5'h00, 32'd0, 4'hF, 1'b0, r1, r0);
        checks++;
        if (r1 !== 32'h1 || r0 !== 32'h1) begin
            failures++;
            $display("FAIL reset_ctrl got %h/%h, required 00000001", r1, r0);
        end
        wb_xfer(5'h10, 32'd0, 4'hF, 1'b0, r1, r0);
        checks++;
        if (r1 !== 32'd0) begin
            failures++;
            $display("FAIL reset_snap got %h, required 0", r1);
        end
    endtask

    task automatic test_basic_count();
        logic [31:0] r1, r0;
        logic tk [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) br_cycle(1'b1, tk[i], i == 1);
        checks++;
        if (tot1 !== 32'd5 || tak1 !== 32'd3 || tot0 !== 32'd5) begin
            failures++;
            $display("FAIL basic_live tot=%0d tak=%0d, required 5 and 3", tot1, tak1);
        end
        wb_xfer(5'h04, 32'd0, 4'hF, 1'b0, r1, r0);
        checks++;
        if (r1 !== 32'd5) begin failures++; $display("FAIL basic_total got %0d, required 5", r1); end
        wb_xfer(5'h08, 32'd0, 4'hF, 1'b0, r1, r0);
        checks++;
        if (r1 !== 32'd3) begin failures++; $display("FAIL basic_taken got %0d, required 3", r1); end
        wb_xfer(5'h0C, 32'd0, 4'hF, 1'b0, r1, r0);
        checks++;
        if (r1 !== 32'd1) begin failures++; $display("FAIL basic_mispred got %0d, required 1", r1); end
    endtask

    task automatic test_saturate();
        logic [31:0] r1, r0;
        wb_xfer(5'h04, 32'hFFFF_FFFE, 4'hF, 1'b1, r1, r0);
        repeat (3) br_cycle(1'b1, 1'b0, 1'b0);
        wb_xfer(5'h04, 32'd0, 4'hF, 1'b0, r1, r0);
        checks++;
        if (r1 !== 32'hFFFF_FFFF || r0 !== 32'd1) begin
            failures++;
            $display("FAIL sat_total got sat=%h wrap=%h, required FFFFFFFF and 00000001", r1, r0);
        end
        wb_xfer(5'h00, 32'd0, 4'hF, 1'b0, r1, r0);
        checks++;
        if (r1 !== 32'h101 || r0 !== 32'h101) begin
            failures++;
            $display("FAIL sat_ovf got sat=%h wrap=%h, required 00000101", r1, r0);
        end
        wb_xfer(5'h00, 32'h703, 4'hF, 1'b1, r1, r0);
        wb_xfer(5'h00, 32'd0, 4'hF, 1'b0, r1, r0);
        checks++;
        if (r1 !== 32'h1 || r0 !== 32'h1) begin
            failures++;
            $display("FAIL ovf_w1c got %h/%h, required 00000001", r1, r0);
        end
    endtask

    task automatic test_clear_snapshot();
        logic [31:0] r1, r0;
        wb_xfer(5'h04, 32'd7, 4'hF, 1'b1, r1, r0);
        br_valid = 1'b1; br_taken = 1'b1; br_mispred = 1'b0;
        wb_xfer(5'h00, 32'h7, 4'hF, 1'b1, r1, r0);
        wb_xfer(5'h10, 32'd0, 4'hF, 1'b0, r1, r0);
        checks++;
        if (r1 !== 32'd8) begin failures++; $display("FAIL snap_total got %0d, required 8", r1); end
        wb_xfer(5'h14, 32'd0, 4'hF, 1'b0, r1, r0);
        checks++;
        if (r1 !== 32'd1) begin failures++; $display("FAIL snap_taken got %0d, required 1", r1); end
        wb_xfer(5'h04, 32'd0, 4'hF, 1'b0, r1, r0);
        checks++;
        if (r1 !== 32'd0 || tot1 !== 32'd0) begin
            failures++;
            $display("FAIL clear_total got %0d live %0d, required 0", r1, tot1);
        end
        wb_xfer(5'h00, 32'd0, 4'hF, 1'b0, r1, r0);
        checks++;
        if (r1 !== 32'h1) begin failures++; $display("FAIL ctrl_pulses got %h, required 00000001", r1); end
    endtask

    task automatic test_disable();
        logic [31:0] r1, r0;
        logic [31:0] prev [3];
        wb_xfer(5'h04, 32'h1234_5678, 4'hF, 1'b1, r1, r0);
        wb_xfer(5'h00, 32'h0, 4'hF, 1'b1, r1, r0);
        for (int k = 0; k < 3; k++) prev[k] = m_cnt[1][k];
        for (int i = 0; i < 10; i++) br_cycle(1'b1, 1'($urandom), 1'($urandom));
        for (int k = 0; k < 3; k++) begin
            wb_xfer(5'(4 * (k + 1)), 32'd0, 4'hF, 1'b0, r1, r0);
            checks++;
            if (r1 !== prev[k]) begin
                failures++;
                $display("FAIL disabled_cnt%0d got %h, required %h", k, r1, prev[k]);
            end
        end
        wb_xfer(5'h04, 32'h0000_005A, 4'b0001, 1'b1, r1, r0);
        wb_xfer(5'h04, 32'd0, 4'hF, 1'b0, r1, r0);
        checks++;
        if (r1 !== 32'h1234_565A) begin
            failures++;
            $display("FAIL byte_write got %h, required 1234565A", r1);
        end
        wb_xfer(5'h00, 32'h1, 4'hF, 1'b1, r1, r0);
    endtask

    task automatic test_random();
        logic [31:0] r1, r0, e1, e0, dat;
        logic [4:0]  adr;
        logic [3:0]  sel;
        logic        we;
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 9) < 6) begin
                br_cycle(1'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                adr = {3'($urandom_range(0, 7)), 2'b00};
                we  = 1'($urandom);
                sel = 4'($urandom);
                dat = $urandom;
                if (adr == 5'h00) dat[0] = ($urandom_range(0, 3) != 0);
                if (adr >= 5'h04 && adr <= 5'h0C && $urandom_range(0, 3) == 0) begin
                    dat = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                    sel = 4'hF;
                end
                br_valid = 1'($urandom); br_taken = 1'($urandom); br_mispred = 1'($urandom);
                e1 = m_read(1, adr);
                e0 = m_read(0, adr);
                wb_xfer(adr, dat, sel, we, r1, r0);
                if (!we) begin
                    checks++;
                    if (r1 !== e1 || r0 !== e0) begin
                        failures++;
                        $display("FAIL rand_read adr=%h got %h/%h, required %h/%h", adr, r1, r0, e1, e0);
                    end
                end
            end
            checks++;
            if (tot1 !== m_cnt[1][0] || tak1 !== m_cnt[1][1] || tot0 !== m_cnt[0][0] || tak0 !== m_cnt[0][1]) begin
                failures++;
                $display("FAIL rand_live step %0d got %h %h %h %h, required %h %h %h %h", n, tot1, tak1,
                         tot0, tak0, m_cnt[1][0], m_cnt[1][1], m_cnt[0][0], m_cnt[0][1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r0;
        int acks;
        logic prev;
        acks = 0; prev = 1'b0;
        wb_adr = 5'h18; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int i = 0; i < 20 && acks < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ((ack1 && prev) || rdt1 !== 32'd0) begin
                failures++;
                $display("FAIL b2b_ack cycle %0d ack=%b prev=%b rdt=%h, required single-cycle ack, rdt 0", i, ack1, prev, rdt1);
            end
            if (ack1) acks++;
            if (acks == 4) begin wb_cyc = 1'b0; wb_stb = 1'b0; end
            prev = ack1;
        end
        @(posedge clk);
        #1;
        checks++;
        if (acks != 4 || ack1 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_count got %0d acks (trailing ack=%b), required 4 then 0", acks, ack1);
        end
        wb_xfer(5'h18, 32'hFFFF_FFFF, 4'hF, 1'b1, r1, r0);
        wb_xfer(5'h1C, 32'd0, 4'hF, 1'b0, r1, r0);
        checks++;
        if (r1 !== 32'd0) begin failures++; $display("FAIL rsvd_read got %h, required 0", r1); end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] r1, r0;
        logic seen;
        br_cycle(1'b1, 1'b1, 1'b1);
        br_cycle(1'b1, 1'b1, 1'b1);
        wb_adr = 5'h04; wb_dat = 32'h1234; wb_sel = 4'hF; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        seen = ack1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        rstn = 1'b1;
        m_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            seen = seen | ack1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL reset_mid_ack got ack=1, required no ack"); end
        for (int k = 0; k < 3; k++) begin
            wb_xfer(5'(4 * (k + 1)), 32'd0, 4'hF, 1'b0, r1, r0);
            checks++;
            if (r1 !== 32'd0) begin
                failures++;
                $display("FAIL reset_mid_cnt%0d got %h, required 0", k, r1);
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_basic_count();
        test_saturate();
        test_clear_snapshot();
        test_disable();
        test_random();
        test_back_to_back();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/swervolf_branch_stats.md
SWERVOLF_BRANCH_STATS -- requirements
Module: swervolf_branch_stats

Interface
REQ-001 Parameters SHALL be: SATURATE, 1, counters stop at 32'hFFFFFFFF when 1 and wrap to 0 when 0; EN_RESET, 1, reset value of CTRL.enable.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  core clock; all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- i_br_valid  in  1  one branch retired this cycle.
- i_br_taken  in  1  retired branch was taken; qualified by i_br_valid.
- i_br_mispred  in  1  retired branch was mispredicted; qualified by i_br_valid.
- i_wb_adr  in  5  Wishbone byte address [4:0]; bits [1:0] ignored.
- i_wb_dat  in  32  write data.
- i_wb_sel  in  4  byte enables.
- i_wb_we  in  1  write strobe.
- i_wb_cyc  in  1  bus cycle.
- i_wb_stb  in  1  strobe.
- o_wb_rdt  out  32  read data.
- o_wb_ack  out  1  transfer acknowledge.
- o_branches_counter  out  32  live TOTAL, feeds the display driver.
- o_branches_taken_counter  out  32  live TAKEN, feeds the display driver.

Function
REQ-003 Register map SHALL be: 0x00 CTRL, 0x04 TOTAL, 0x08 TAKEN, 0x0C MISPRED, 0x10 SNAP_TOTAL, 0x14 SNAP_TAKEN; 0x18 and 0x1C read 0 and ignore writes.
REQ-004 CTRL SHALL hold bit0 enable (R/W), bit1 clear (write-1 pulse, reads 0), bit2 snapshot (write-1 pulse, reads 0), bits[10:8] sticky overflow for TOTAL/TAKEN/MISPRED (write-1-to-clear).
REQ-005 With enable=1 and i_br_valid=1, TOTAL SHALL increment by 1; TAKEN SHALL also increment if i_br_taken; MISPRED SHALL also increment if i_br_mispred. All three are updated in the same edge.
REQ-006 Counter update latency SHALL be 1 cycle: the event sampled at edge N is visible on the outputs and in register reads after edge N.
REQ-007 With enable=0, event inputs SHALL be ignored.
REQ-008 A counter at 32'hFFFFFFFF receiving an increment SHALL hold its value when SATURATE=1 and wrap to 0 when SATURATE=0; in both cases its overflow bit SHALL be set.
REQ-009 When a clear pulse and an event occur in the same cycle, clear SHALL win: all three counters go to 0 and the event is dropped. Overflow bits are not cleared.
REQ-010 A snapshot pulse SHALL copy the post-update TOTAL and TAKEN values into SNAP_TOTAL and SNAP_TAKEN. Snapshot together with clear SHALL capture the pre-clear values plus the current event.
REQ-011 A Wishbone write to TOTAL, TAKEN or MISPRED SHALL load the value byte-wise per i_wb_sel. The write overrides any event increment in the same cycle for that counter only.
REQ-012 SNAP registers SHALL be read-only.
REQ-013 o_wb_ack SHALL assert exactly one cycle after i_wb_cyc & i_wb_stb is seen with ack low, for one cycle only. Each strobe SHALL produce exactly one ack. Register side effects SHALL occur on the ack cycle.
REQ-014 o_wb_rdt SHALL be valid during ack and 0 otherwise.
REQ-015 Dropping i_wb_cyc before ack SHALL abort the access with no side effects.

Reset
REQ-016 On rstn low, the following SHALL clear immediately: all counters, all SNAP registers, overflow bits, o_wb_ack and o_wb_rdt. enable SHALL take the value EN_RESET.
REQ-017 A reset asserted mid-access SHALL drop the pending ack; the master re-issues the access.

Structure
REQ-018 The shared package swervolf_branch_stats_pkg SHALL hold the register offsets, the CTRL bit positions and the counter width constant (32).
REQ-019 One sub-module, bs_sat_counter, SHALL be instantiated three times. It has a SATURATE parameter and inputs inc, clr, load, load_data and load_be, and outputs count and ovf_pulse.

Verification
REQ-020 Reset, enable=1, 5 branches with taken pattern 1,0,1,1,0 and mispredict on the 2nd branch -> TOTAL=5, TAKEN=3, MISPRED=1, o_branches_counter=5.
REQ-021 Write TOTAL=32'hFFFFFFFE, then 3 branches -> SATURATE=1: TOTAL=32'hFFFFFFFF and CTRL[8]=1; SATURATE=0: TOTAL=1 and CTRL[8]=1.
REQ-022 TOTAL=7, then CTRL write 0x7 in the same cycle as a branch event -> SNAP_TOTAL=8, TOTAL=0, next read of CTRL=0x1.
REQ-023 enable=0 with 10 branch events -> all counters are unchanged; a write of 0x5A to TOTAL with sel=4'b0001 changes only byte 0.
REQ-024 Back-to-back held strobes over 4 accesses -> exactly 4 single-cycle acks. Reads of 0x18 return 0. rstn pulsed between strobe and ack -> no ack is issued and the counters read 0.
